// File: rtl/demux_5_1_2_buf_if.sv
// demux_5_1_2_buf_if
// Bundles the input handshake and both output handshakes of the buffered 1:2 demux.
//   master : source/consumer side (drives in_*, out*_ready; observes in_ready, out*_data/valid)
//   slave  : demux side (the inverse)
// Optional macro DEMUX_STATS_EN adds the cnt0/cnt1 per-port push counters.
interface demux_5_1_2_buf_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
`ifdef DEMUX_STATS_EN
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;
`endif

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX_STATS_EN
    , input cnt0, cnt1
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX_STATS_EN
    , output cnt0, cnt1
`endif
  );
endinterface

// File: rtl/demux_5_1_2_buf.sv
// demux_5_1_2_buf
// Buffered 1-to-2 demultiplexer. Each accepted input item is steered by in_sel into
// one of two DEPTH-entry FIFOs; each FIFO drains on its own valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (empties both FIFOs, clears counters)
//   bus  - demux_5_1_2_buf_if.slave: in_data/in_sel/in_valid/in_ready,
//          out0_data/out0_valid/out0_ready, out1_data/out1_valid/out1_ready,
//          and cnt0/cnt1 when DEMUX_STATS_EN is defined
// Optional feature macro: DEMUX_STATS_EN (saturating 8-bit per-port push counters).
module demux_5_1_2_buf #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  demux_5_1_2_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL  = 2'd2
  } port_state_t;

  port_state_t      state     [2];
  port_state_t      state_nxt [2];
  logic [CW-1:0]    count     [2];
  logic [CW-1:0]    count_nxt [2];
  logic [AW-1:0]    wr_ptr    [2];
  logic [AW-1:0]    rd_ptr    [2];
  logic [WIDTH-1:0] mem       [2][DEPTH];
  logic [WIDTH-1:0] head      [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic             in_ready;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // in_ready looks only at the registered state of the selected port, so a FULL
  // port refuses a push even in the cycle it is being popped.
  always_comb begin
    in_ready  = (state[bus.in_sel] != FULL);
    push      = '0;
    pop       = '0;
    out_valid = '0;
    for (int p = 0; p < 2; p++) begin
      out_valid[p] = (state[p] != EMPTY);
      head[p]      = out_valid[p] ? mem[p][rd_ptr[p]] : '0;
      push[p]      = bus.in_valid && in_ready && (bus.in_sel == 1'(p));
      pop[p]       = out_valid[p] && out_ready[p];
      count_nxt[p] = count[p] + CW'(push[p]) - CW'(pop[p]);
      if (count_nxt[p] == '0)
        state_nxt[p] = EMPTY;
      else if (count_nxt[p] == CW'(DEPTH))
        state_nxt[p] = FULL;
      else
        state_nxt[p] = PART;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        state[p] <= EMPTY;
        count[p] <= '0;
      end else begin
        state[p] <= state_nxt[p];
        count[p] <= count_nxt[p];
      end
    end
  end

  // Pointers wrap silently because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end else begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
      end
    end
  end

  // Storage needs no reset: out*_data is forced to zero while a port is EMPTY.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = out_valid[0];
  assign bus.out1_valid = out_valid[1];
  assign bus.out0_data  = head[0];
  assign bus.out1_data  = head[1];

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt [2];

  // Counters saturate at 8'hFF rather than wrapping.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst)
        cnt[p] <= '0;
      else if (push[p] && (cnt[p] != 8'hFF))
        cnt[p] <= cnt[p] + 8'd1;
    end
  end

  assign bus.cnt0 = cnt[0];
  assign bus.cnt1 = cnt[1];
`endif
endmodule

// File: tb/tb_demux_5_1_2_buf.sv
// tb_demux_5_1_2_buf
// Drives directed and random traffic into demux_5_1_2_buf and compares every cycle
// against two queue-based FIFO models (plus saturating counters with DEMUX_STATS_EN).
module tb_demux_5_1_2_buf;
  localparam int WIDTH = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_5_1_2_buf_if #(.WIDTH(WIDTH)) bus ();

  demux_5_1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
`ifdef DEMUX_STATS_EN
  int m_cnt0 = 0;
  int m_cnt1 = 0;
`endif

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check_output("out0_valid", 32'(bus.out0_valid), 32'(q0.size() > 0));
    check_output("out0_data", 32'(bus.out0_data), (q0.size() > 0) ? 32'(q0[0]) : 32'd0);
    check_output("out1_valid", 32'(bus.out1_valid), 32'(q1.size() > 0));
    check_output("out1_data", 32'(bus.out1_data), (q1.size() > 0) ? 32'(q1[0]) : 32'd0);
`ifdef DEMUX_STATS_EN
    check_output("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
    check_output("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
`endif
  endtask

  // One cycle: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic apply_stimulus(input logic [WIDTH-1:0] d, input logic sel, input logic v,
                                input logic r0, input logic r1);
    logic exp_ready, do_push, do_pop0, do_pop1;
    bus.in_data    = d;
    bus.in_sel     = sel;
    bus.in_valid   = v;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
    exp_ready = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    do_push = v && exp_ready;
    do_pop0 = r0 && (q0.size() > 0);
    do_pop1 = r1 && (q1.size() > 0);
    @(posedge clk);
    if (do_pop0) void'(q0.pop_front());
    if (do_pop1) void'(q1.pop_front());
    if (do_push) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
`ifdef DEMUX_STATS_EN
      if (sel) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
      else     m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
`endif
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset(input int cycles);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    q0.delete();
    q1.delete();
`ifdef DEMUX_STATS_EN
    m_cnt0 = 0;
    m_cnt1 = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    check_model();
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_data    = '0;
    bus.in_sel     = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset for two cycles, then check idle outputs and in_ready on both selects.
    do_reset(2);
    bus.in_sel = 1'b0; #1;
    check_output("rst_in_ready_sel0", 32'(bus.in_ready), 32'd1);
    bus.in_sel = 1'b1; #1;
    check_output("rst_in_ready_sel1", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Routing: 0A to port 0, 15 to port 1, each drains after one cycle.
    apply_stimulus(5'h0A, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("t2_out0_0A", 32'(bus.out0_data), 32'h0A);
    apply_stimulus(5'h15, 1'b1, 1'b1, 1'b1, 1'b1);
    check_output("t2_out1_15", 32'(bus.out1_data), 32'h15);
    check_output("t2_out0_drained", 32'(bus.out0_valid), 32'd0);
    apply_stimulus(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Stall port 0 until FULL; port 1 still accepts.
    apply_stimulus(5'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    apply_stimulus(5'h02, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.in_sel = 1'b0; bus.in_valid = 1'b0; #1;
    check_output("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    apply_stimulus(5'h07, 1'b0, 1'b1, 1'b0, 1'b1);
    apply_stimulus(5'h1F, 1'b1, 1'b1, 1'b0, 1'b1);
    check_output("t3_out1_1F", 32'(bus.out1_data), 32'h1F);
    check_output("t3_out0_head", 32'(bus.out0_data), 32'h01);

    // Release port 0 while pushing to it: the pop cycle still refuses the push.
    apply_stimulus(5'h03, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("t4_out0_02", 32'(bus.out0_data), 32'h02);
    apply_stimulus(5'h03, 1'b0, 1'b1, 1'b1, 1'b1);
    apply_stimulus(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(5'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Streaming six items through port 1: pointers wrap, one item per cycle.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(WIDTH'(i), 1'b1, 1'b1, 1'b1, 1'b1);
      check_output("t5_stream", 32'(bus.out1_data), 32'(i));
    end

    // Fill both ports, then reset for one cycle.
    apply_stimulus(5'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(5'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    check_output("t6_out0_valid", 32'(bus.out0_valid), 32'd0);
    check_output("t6_out1_data", 32'(bus.out1_data), 32'd0);
    apply_stimulus(5'h0C, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("t6_post_push", 32'(bus.out1_data), 32'h0C);

    // Random traffic with independently varying readies.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(WIDTH'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    end

`ifdef DEMUX_STATS_EN
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(WIDTH'($urandom), 1'b0, 1'b1, 1'b1, 1'b1);
    end
    check_output("t7_cnt0_sat", 32'(bus.cnt0), 32'hFF);
    check_output("t7_cnt1_zero", 32'(bus.cnt1), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
